// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imem_pkg
// Purpose : Shared definitions for the instruction fetch unit. Holds the
//           default parameter values, NOP encoding, response fault bit
//           encodings and the load/fetch FSM state type.
// Ports   : (package, none)
// Rev     : 1.0  initial release
// ============================================================================
package imem_pkg;

    localparam int DEF_INSTR_WIDTH = 32;
    localparam int DEF_DEPTH_WORDS = 64;
    localparam int DEF_ADDR_WIDTH  = 32;

    // NOP is the all-zeros word; replicate this bit to any instruction width.
    localparam logic NOP_BIT = 1'b0;

    localparam int  FAULT_MISALIGN_BIT = 0;
    localparam int  FAULT_RANGE_BIT    = 1;
    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        LOAD  = 1'b1
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/imem_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module  : imem_rsp_fifo
// Purpose : Two-entry response FIFO. Head entry is presented combinationally
//           and stays stable until popped. Push and pop in the same cycle are
//           allowed even when full. flush empties the FIFO and dominates
//           push/pop.
// Ports   : clk, rst            clock, synchronous active-high reset
//           flush               discard all entries
//           push, push_data     write strobe / entry
//           pop                 consume head entry
//           out_valid, out_data head entry valid / contents
//           count               number of stored entries (0..2)
// Rev     : 1.0  initial release
// ============================================================================
module imem_rsp_fifo #(
    parameter int WIDTH = 66
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot_q [2];
    logic [WIDTH-1:0] slot_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != 2'd0);
        // A full FIFO still accepts a push when the head leaves this cycle.
        do_push  = push && ((count_q != 2'd2) || do_pop);
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                slot_d[wr_ptr_q] = push_data;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            slot_q    <= slot_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = slot_q[rd_ptr_q];
    assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/imem_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : imem_fetch_unit
// Purpose : Instruction memory with a program-load port and a pipelined fetch
//           port. A fetch accepted at edge N is held as the in-flight entry,
//           read from storage and pushed into the response FIFO at edge N+1.
//           Misaligned / out-of-range fetches return NOP with fault bits.
// Ports   : clk, rst                         clock, sync active-high reset
//           load_en, load_addr, load_data    program-load write port
//           req_valid, req_ready, req_addr   fetch request handshake
//           flush                            drop in-flight + buffered rsps
//           rsp_valid, rsp_ready             response handshake
//           rsp_instr, rsp_addr, rsp_fault   response payload
// Rev     : 1.0  initial release
// ============================================================================
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [ADDR_WIDTH-1:0]  load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic                   flush,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [INSTR_WIDTH-1:0] rsp_instr,
    output logic [ADDR_WIDTH-1:0]  rsp_addr,
    output logic [1:0]             rsp_fault
);

    localparam int IDX_W   = $clog2(DEPTH_WORDS);
    localparam int ENTRY_W = INSTR_WIDTH + ADDR_WIDTH + 2;
    // One extra bit so the byte limit is representable and the compare never wraps.
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(4 * DEPTH_WORDS);

    logic [INSTR_WIDTH-1:0] mem_q [DEPTH_WORDS];

    fetch_state_e          state_q, state_d;
    logic                  inflight_valid_q, inflight_valid_d;
    logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;
    logic [1:0]            inflight_fault_q, inflight_fault_d;

    logic                   load_ok;
    logic [1:0]             req_fault;
    logic [2:0]             occupancy;
    logic                   accept;
    logic [INSTR_WIDTH-1:0] rd_instr;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic [1:0]             fifo_count;
    logic                   fifo_valid;
    logic [ENTRY_W-1:0]     fifo_out;

    always_comb begin
        load_ok = load_en && (load_addr[1:0] == 2'b00) && ({1'b0, load_addr} < LIMIT);

        req_fault = FAULT_NONE;
        req_fault[FAULT_MISALIGN_BIT] = (req_addr[1:0] != 2'b00);
        req_fault[FAULT_RANGE_BIT]    = ({1'b0, req_addr} >= LIMIT);

        occupancy = {1'b0, fifo_count} + {2'b00, inflight_valid_q};
        // flush frees every slot at this edge, so a request may ride along.
        req_ready = (state_q == FETCH) && (flush || (occupancy < 3'd2));
        accept    = req_valid && req_ready;

        state_d = state_q;
        case (state_q)
            FETCH:   if (load_en)  state_d = LOAD;
            LOAD:    if (!load_en) state_d = FETCH;
            default: state_d = FETCH;
        endcase

        // The in-flight slot always drains next edge, so it only holds the
        // request accepted this cycle (which survives a concurrent flush).
        inflight_valid_d = accept;
        inflight_addr_d  = accept ? req_addr  : inflight_addr_q;
        inflight_fault_d = accept ? req_fault : inflight_fault_q;

        rd_instr = (inflight_fault_q != FAULT_NONE) ? {INSTR_WIDTH{NOP_BIT}}
                                                    : mem_q[inflight_addr_q[IDX_W+1:2]];
        fifo_push = inflight_valid_q && !flush;
        fifo_pop  = fifo_valid && rsp_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= FETCH;
            inflight_valid_q <= 1'b0;
            inflight_addr_q  <= '0;
            inflight_fault_q <= FAULT_NONE;
        end else begin
            state_q          <= state_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_addr_q  <= inflight_addr_d;
            inflight_fault_q <= inflight_fault_d;
        end
    end

    // Storage keeps its contents across reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && load_ok) begin
            mem_q[load_addr[IDX_W+1:2]] <= load_data;
        end
    end

    imem_rsp_fifo #(
        .WIDTH (ENTRY_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (fifo_push),
        .push_data ({rd_instr, inflight_addr_q, inflight_fault_q}),
        .pop       (fifo_pop),
        .out_valid (fifo_valid),
        .out_data  (fifo_out),
        .count     (fifo_count)
    );

    assign rsp_valid = fifo_valid;
    assign {rsp_instr, rsp_addr, rsp_fault} = fifo_out;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_fetch_unit
// Purpose : Directed self-checking bench for imem_fetch_unit.
// Rev     : 1.0  initial release
// ============================================================================
module tb_imem_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic [1:0]  rsp_fault;

    int vec = 0;
    int errs = 0;

    imem_fetch_unit #(
        .INSTR_WIDTH (32),
        .DEPTH_WORDS (64),
        .ADDR_WIDTH  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_fault (rsp_fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", rsp_valid); end
        rst = 1'b0;
        step();
        vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_valid2: got %b want 0", rsp_valid); end
        vec++; if (rsp_instr !== 32'h0) begin errs++; $display("FAIL rst_instr: got %h want 0", rsp_instr); end
        vec++; if (rsp_addr !== 32'h0) begin errs++; $display("FAIL rst_addr: got %h want 0", rsp_addr); end
        vec++; if (rsp_fault !== 2'b00) begin errs++; $display("FAIL rst_fault: got %b want 00", rsp_fault); end
        vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_load_fetch();
        rsp_ready = 1'b1;
        load_en = 1'b1; load_addr = 32'h0; load_data = 32'h20010008;
        step();
        vec++; if (req_ready !== 1'b0) begin errs++; $display("FAIL load_ready: got %b want 0", req_ready); end
        load_addr = 32'h4; load_data = 32'h3402000C;
        step();
        load_addr = 32'h8; load_data = 32'hA5A50F0F;
        step();
        load_en = 1'b0;
        step();
        vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL load_exit_ready: got %b want 1", req_ready); end
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL lat_early: got %b want 0", rsp_valid); end
        req_addr = 32'h4;
        step();
        vec++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid0: got %b want 1", rsp_valid); end
        vec++; if (rsp_instr !== 32'h20010008) begin errs++; $display("FAIL b2b_instr0: got %h want 20010008", rsp_instr); end
        vec++; if (rsp_addr !== 32'h0) begin errs++; $display("FAIL b2b_addr0: got %h want 0", rsp_addr); end
        vec++; if (rsp_fault !== 2'b00) begin errs++; $display("FAIL b2b_fault0: got %b want 00", rsp_fault); end
        req_valid = 1'b0;
        step();
        vec++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid1: got %b want 1", rsp_valid); end
        vec++; if (rsp_instr !== 32'h3402000C) begin errs++; $display("FAIL b2b_instr1: got %h want 3402000C", rsp_instr); end
        vec++; if (rsp_addr !== 32'h4) begin errs++; $display("FAIL b2b_addr1: got %h want 4", rsp_addr); end
        step();
        vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain: got %b want 0", rsp_valid); end
    endtask

    task automatic test_faults();
        logic [31:0] a [5];
        logic [31:0] ei [5];
        logic [1:0]  ef [5];
        a[0] = 32'h6;        ei[0] = 32'h0;        ef[0] = 2'b01;
        a[1] = 32'h100;      ei[1] = 32'h0;        ef[1] = 2'b10;
        a[2] = 32'h102;      ei[2] = 32'h0;        ef[2] = 2'b11;
        a[3] = 32'h4;        ei[3] = 32'h3402000C; ef[3] = 2'b00;
        a[4] = 32'hFFFFFFFC; ei[4] = 32'h0;        ef[4] = 2'b10;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_addr = a[i];
            step();
            req_valid = 1'b0;
            step();
            vec++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL flt_valid[%0d]: got %b want 1", i, rsp_valid); end
            vec++; if (rsp_instr !== ei[i]) begin errs++; $display("FAIL flt_instr[%0d]: got %h want %h", i, rsp_instr, ei[i]); end
            vec++; if (rsp_addr !== a[i]) begin errs++; $display("FAIL flt_addr[%0d]: got %h want %h", i, rsp_addr, a[i]); end
            vec++; if (rsp_fault !== ef[i]) begin errs++; $display("FAIL flt_fault[%0d]: got %b want %b", i, rsp_fault, ef[i]); end
            step();
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        req_addr = 32'h4;
        step();
        req_addr = 32'h8;
        vec++; if (req_ready !== 1'b0) begin errs++; $display("FAIL bp_ready_full: got %b want 0", req_ready); end
        vec++; if (rsp_addr !== 32'h0) begin errs++; $display("FAIL bp_head0: got %h want 0", rsp_addr); end
        step();
        vec++; if (req_ready !== 1'b0) begin errs++; $display("FAIL bp_ready_full2: got %b want 0", req_ready); end
        step();
        vec++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL bp_hold_valid: got %b want 1", rsp_valid); end
        vec++; if (rsp_addr !== 32'h0) begin errs++; $display("FAIL bp_hold_addr: got %h want 0", rsp_addr); end
        vec++; if (rsp_instr !== 32'h20010008) begin errs++; $display("FAIL bp_hold_instr: got %h want 20010008", rsp_instr); end
        rsp_ready = 1'b1;
        step();
        vec++; if (rsp_addr !== 32'h4) begin errs++; $display("FAIL bp_second: got %h want 4", rsp_addr); end
        vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL bp_ready_back: got %b want 1", req_ready); end
        step();
        req_valid = 1'b0;
        vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL bp_gap: got %b want 0", rsp_valid); end
        step();
        vec++; if (rsp_addr !== 32'h8) begin errs++; $display("FAIL bp_third_addr: got %h want 8", rsp_addr); end
        vec++; if (rsp_instr !== 32'hA5A50F0F) begin errs++; $display("FAIL bp_third_instr: got %h want A5A50F0F", rsp_instr); end
        step();
        vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL bp_drain: got %b want 0", rsp_valid); end
    endtask

    task automatic test_flush();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        req_addr = 32'h4;
        step();
        req_valid = 1'b0;
        step();
        vec++; if (req_ready !== 1'b0) begin errs++; $display("FAIL fl_ready_pre: got %b want 0", req_ready); end
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h8;
        #1;
        vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL fl_ready: got %b want 1", req_ready); end
        step();
        flush = 1'b0; req_valid = 1'b0;
        vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL fl_cleared: got %b want 0", rsp_valid); end
        rsp_ready = 1'b1;
        step();
        vec++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL fl_survivor_valid: got %b want 1", rsp_valid); end
        vec++; if (rsp_addr !== 32'h8) begin errs++; $display("FAIL fl_survivor_addr: got %h want 8", rsp_addr); end
        step();
        vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL fl_only_one: got %b want 0", rsp_valid); end
    endtask

    task automatic test_load_pending();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h8;
        step();
        req_valid = 1'b0;
        load_en = 1'b1; load_addr = 32'h8; load_data = 32'hDEADBEEF;
        step();
        vec++; if (req_ready !== 1'b0) begin errs++; $display("FAIL lp_ready: got %b want 0", req_ready); end
        vec++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL lp_valid: got %b want 1", rsp_valid); end
        vec++; if (rsp_instr !== 32'hA5A50F0F) begin errs++; $display("FAIL lp_old: got %h want A5A50F0F", rsp_instr); end
        load_addr = 32'h2; load_data = 32'hFFFFFFFF;
        step();
        load_addr = 32'h100;
        step();
        load_en = 1'b0; rsp_ready = 1'b1;
        step();
        vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL lp_ready_back: got %b want 1", req_ready); end
        vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL lp_drained: got %b want 0", rsp_valid); end
        req_valid = 1'b1; req_addr = 32'h8;
        step();
        req_valid = 1'b0;
        step();
        vec++; if (rsp_instr !== 32'hDEADBEEF) begin errs++; $display("FAIL lp_new: got %h want DEADBEEF", rsp_instr); end
        step();
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        req_valid = 1'b0;
        step();
        vec++; if (rsp_instr !== 32'h20010008) begin errs++; $display("FAIL lp_bad_load_ignored: got %h want 20010008", rsp_instr); end
        step();
    endtask

    task automatic test_reset_full();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        req_addr = 32'h4;
        step();
        req_valid = 1'b0;
        step();
        vec++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL rf_full: got %b want 1", rsp_valid); end
        rst = 1'b1; load_en = 1'b1; load_addr = 32'h4; load_data = 32'h0;
        req_valid = 1'b1; req_addr = 32'h8;
        step();
        vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rf_valid: got %b want 0", rsp_valid); end
        vec++; if (rsp_instr !== 32'h0) begin errs++; $display("FAIL rf_instr: got %h want 0", rsp_instr); end
        vec++; if (rsp_addr !== 32'h0) begin errs++; $display("FAIL rf_addr: got %h want 0", rsp_addr); end
        rst = 1'b0; load_en = 1'b0; req_valid = 1'b0;
        step();
        vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rf_ready: got %b want 1", req_ready); end
        vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rf_no_ghost: got %b want 0", rsp_valid); end
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h4;
        step();
        req_valid = 1'b0;
        step();
        vec++; if (rsp_instr !== 32'h3402000C) begin errs++; $display("FAIL rf_kept: got %h want 3402000C", rsp_instr); end
        step();
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_faults();
        test_backpressure();
        test_flush();
        test_load_pending();
        test_reset_full();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
`default_nettype wire
